// File: rtl/sram_pkg.sv
// Shared sizing for the 8x8 single-port SRAM and the FIFO controller in front of it.
package sram_pkg;
   localparam int SRAM_DATA_W = 8;
   localparam int SRAM_ADDR_W = 3;
   localparam int SRAM_DEPTH  = 8;

   typedef logic [SRAM_DATA_W-1:0] word_t;
endpackage

// File: rtl/sram1.sv
// 8x8 single-port SRAM: writes and reads sampled on the rising edge, registered read data.
module sram1
   import sram_pkg::*;
(
   input  logic                   clk,
   input  logic                   wr,
   input  logic                   rd,
   input  logic [SRAM_ADDR_W-1:0] add,
   input  word_t                  data_in,
   output word_t                  data_out
);
   word_t mem_q [SRAM_DEPTH];
   word_t data_out_q;

   always_ff @(posedge clk) begin
      if (wr) mem_q[add] <= data_in;
      if (rd) data_out_q <= mem_q[add];
   end

   assign data_out = data_out_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller owning every access to sram1, with a show-ahead output register.
module sram_fifo_ctrl
   import sram_pkg::*;
#(
   parameter int DATA_W = SRAM_DATA_W,
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DEPTH  = SRAM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   level,
   output logic [DATA_W-1:0] sram_data_in,
   output logic              sram_wr,
   output logic              sram_rd,
   output logic [ADDR_W-1:0] sram_add,
   input  logic [DATA_W-1:0] sram_data_out
);
   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              rd_inflight_q, rd_inflight_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              rd_issue;
   logic              push;

   always_comb begin
      // Refilling the empty output register wins the single SRAM port over a push.
      rd_issue      = (level_q != '0) && !rd_inflight_q && !out_valid_q;
      in_ready      = !rst && (level_q < LEVEL_FULL) && !rd_issue;
      push          = in_valid && in_ready;

      sram_wr       = push;
      sram_rd       = !rst && rd_issue;
      sram_add      = '0;
      sram_data_in  = '0;
      if (!rst) begin
         sram_add     = rd_issue ? rd_ptr_q : wr_ptr_q;
         sram_data_in = in_data;
      end

      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      rd_inflight_d = rd_issue;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         level_d  = level_q + (ADDR_W+1)'(1);
      end else if (rd_issue) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         level_d  = level_q - (ADDR_W+1)'(1);
      end

      if (rd_inflight_q) begin
         out_data_d  = sram_data_out;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         rd_inflight_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         rd_inflight_q <= rd_inflight_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign level     = level_q;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl driving a real sram1, with an in-order data scoreboard.
module tb_sram_fifo_ctrl;
   import sram_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  level;
   logic [7:0]  sram_data_in;
   logic        sram_wr;
   logic        sram_rd;
   logic [2:0]  sram_add;
   logic [7:0]  sram_data_out;

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   int          n_pop = 0;
   int          last_pop = 0;
   bit          have_last = 0;
   bit          chk_interval = 0;
   logic [7:0]  sb[$];

   always #5 clk = ~clk;

   sram_fifo_ctrl dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .sram_data_in(sram_data_in), .sram_wr(sram_wr), .sram_rd(sram_rd),
      .sram_add(sram_add), .sram_data_out(sram_data_out)
   );

   sram1 u_sram (
      .clk(clk), .wr(sram_wr), .rd(sram_rd), .add(sram_add),
      .data_in(sram_data_in), .data_out(sram_data_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock: record accepted pushes and completed pops, then advance to the next falling edge.
   task automatic tick();
      logic [7:0] exp_word;
      #1;
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("pop_with_empty_scoreboard", 32'd1, 32'd0);
         else begin
            exp_word = sb.pop_front();
            chk("pop_data", {24'd0, out_data}, {24'd0, exp_word});
         end
         if (chk_interval && have_last) chk("pop_interval", cyc - last_pop, 32'd3);
         have_last = 1;
         last_pop  = cyc;
         n_pop++;
      end
      chk("port_exclusive", {31'd0, sram_wr & sram_rd}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      int pushed;
      int stalls;
      bit acc;

      rst = 1; in_valid = 1; in_data = 8'hFF; out_ready = 0;
      @(negedge clk);
      tick(); tick();
      #1;
      chk("rst_in_ready",  {31'd0, in_ready}, 0);
      chk("rst_sram_wr",   {31'd0, sram_wr}, 0);
      chk("rst_sram_rd",   {31'd0, sram_rd}, 0);
      chk("rst_sram_add",  {29'd0, sram_add}, 0);
      chk("rst_sram_din",  {24'd0, sram_data_in}, 0);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_level",     {28'd0, level}, 0);
      chk("rst_out_data",  {24'd0, out_data}, 0);

      // Single push: write, then read, then output three cycles after the push edge.
      rst = 0; in_valid = 1; in_data = 8'hAA;
      #1;
      chk("p1_in_ready", {31'd0, in_ready}, 1);
      chk("p1_wr",       {31'd0, sram_wr}, 1);
      chk("p1_add",      {29'd0, sram_add}, 0);
      chk("p1_din",      {24'd0, sram_data_in}, 32'hAA);
      tick();
      in_valid = 0;
      #1;
      chk("p1_rd",       {31'd0, sram_rd}, 1);
      chk("p1_rd_wr",    {31'd0, sram_wr}, 0);
      chk("p1_rd_add",   {29'd0, sram_add}, 0);
      chk("p1_level1",   {28'd0, level}, 1);
      tick();
      chk("p1_level0",   {28'd0, level}, 0);
      chk("p1_ov_early", {31'd0, out_valid}, 0);
      tick();
      chk("p1_ov",       {31'd0, out_valid}, 1);
      chk("p1_od",       {24'd0, out_data}, 32'hAA);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("p1_ov_after_pop", {31'd0, out_valid}, 0);
      chk("p1_sb_empty", sb.size(), 0);

      // Fill with in_valid held; the one read-issue cycle must stall the push.
      pushed = 0; stalls = 0;
      for (int b = 0; b < 40 && pushed < 9; b++) begin
         in_valid = 1; in_data = 8'h10 + 8'(pushed);
         #1;
         if (in_ready) pushed++;
         else begin
            stalls++;
            chk("contend_rd", {31'd0, sram_rd}, 1);
            chk("contend_wr", {31'd0, sram_wr}, 0);
         end
         tick();
      end
      in_valid = 0;
      chk("fill_pushed", pushed, 9);
      chk("fill_stalls", stalls, 1);
      tick(); tick();
      chk("full_level",    {28'd0, level}, 8);
      chk("full_in_ready", {31'd0, in_ready}, 0);
      chk("full_ov",       {31'd0, out_valid}, 1);
      chk("full_od",       {24'd0, out_data}, 32'h10);
      in_valid = 1; in_data = 8'h99;
      tick(); tick();
      in_valid = 0;
      chk("stall_level",   {28'd0, level}, 8);
      chk("stall_sb",      sb.size(), 9);

      // Drain at one word per three cycles; data order proves the 7->0 read wrap.
      out_ready = 1; n_pop = 0; have_last = 0; chk_interval = 1;
      for (int b = 0; b < 60 && sb.size() > 0; b++) tick();
      chk_interval = 0;
      chk("drain_pops", n_pop, 9);
      tick(); tick();
      chk("drain_level", {28'd0, level}, 0);
      chk("drain_ov",    {31'd0, out_valid}, 0);

      // Interleaved push/pop pairs carrying their index.
      n_pop = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1; in_data = 8'(i); acc = 0;
         for (int b = 0; b < 10 && !acc; b++) begin
            #1;
            acc = in_ready;
            tick();
         end
         in_valid = 0;
         if (!acc) chk("wrap_push_timeout", 32'd1, 32'd0);
         for (int b = 0; b < 10 && n_pop < i + 1; b++) tick();
      end
      out_ready = 0;
      chk("wrap_pops", n_pop, 20);
      chk("wrap_sb",   sb.size(), 0);

      // Reset in the cycle after a read issue.
      in_valid = 1; in_data = 8'h33;
      tick();
      in_valid = 0;
      #1;
      chk("mid_rd", {31'd0, sram_rd}, 1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      sb.delete();
      #1;
      chk("mid_ov",    {31'd0, out_valid}, 0);
      chk("mid_level", {28'd0, level}, 0);
      tick(); tick();
      chk("mid_ov_later", {31'd0, out_valid}, 0);
      in_valid = 1; in_data = 8'h55;
      #1;
      chk("post_wr",     {31'd0, sram_wr}, 1);
      chk("post_wr_add", {29'd0, sram_add}, 0);
      tick();
      in_valid = 0;
      #1;
      chk("post_rd_add", {29'd0, sram_add}, 0);
      tick(); tick();
      chk("post_ov", {31'd0, out_valid}, 1);
      chk("post_od", {24'd0, out_data}, 32'h55);
      out_ready = 1;
      tick();
      out_ready = 0;
      chk("post_sb", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Single-clock FIFO controller that uses the 8x8 single-port SRAM (sram1) as its storage array.
- Converts a valid/ready push stream and a valid/ready pop stream into the SRAM's wr/rd/add/data_in strobes.
- Holds the head word in a show-ahead output register.
- Sits directly upstream of sram1: it owns every SRAM access and consumes sram1's data_out.

Parameters:
- DATA_W, 8, word width; must match the SRAM data width.
- ADDR_W, 3, SRAM address width.
- DEPTH, 8, SRAM words used; equals 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  push data.
- in_valid  in  1  push request.
- in_ready  out  1  controller accepts push this cycle.
- out_data  out  DATA_W  head word; the output register.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer takes out_data this cycle.
- level  out  ADDR_W+1  words stored in SRAM, 0..DEPTH; excludes in-flight read and output register.
- sram_data_in  out  DATA_W  to sram1 data_in.
- sram_wr  out  1  to sram1 wr.
- sram_rd  out  1  to sram1 rd.
- sram_add  out  ADDR_W  to sram1 add.
- sram_data_out  in  DATA_W  from sram1 data_out.

Behaviour:
SRAM contract:
- sram1 samples wr/rd/add/data_in on the clk rising edge.
- Read data is valid on sram_data_out for the whole cycle after the edge that sampled rd=1.
- The SRAM port is single: at most one of sram_wr or sram_rd is high in any cycle.

State:
- wr_ptr, rd_ptr: ADDR_W bits each; wrap DEPTH-1 -> 0.
- level: ADDR_W+1 bits.
- rd_inflight: 1 bit.
- out_valid: 1 bit.
- out_data: registered.

Reset (rst=1 at an edge):
- wr_ptr=0, rd_ptr=0, level=0, rd_inflight=0, out_valid=0, out_data=0.
- While rst=1: in_ready=0, sram_wr=0, sram_rd=0, sram_add=0, sram_data_in=0.
- Reset mid-operation discards any in-flight read and the output word. SRAM contents are not cleared; they are ignored.

Per-cycle decisions, combinational from registered state:
- rd_issue = level>0 && !rd_inflight && !out_valid.
- in_ready = level<DEPTH && !rd_issue. A read issue has priority over a push.
- push = in_valid && in_ready.
  - On push: sram_wr=1, sram_add=wr_ptr, sram_data_in=in_data.
  - At the edge: wr_ptr+1, level+1.
- On rd_issue: sram_rd=1, sram_add=rd_ptr.
  - At the edge: rd_ptr+1, level-1, rd_inflight=1.
- Idle cycle (neither push nor rd_issue): sram_wr=0, sram_rd=0, sram_add=wr_ptr, sram_data_in=in_data.
- Push and rd_issue are mutually exclusive, so level never increments and decrements in the same cycle.

Capture and pop:
- rd_inflight=1: at the edge, out_data<=sram_data_out, out_valid<=1, rd_inflight<=0.
- Pop: out_valid && out_ready at an edge clears out_valid, unless a capture occurs at that same edge. A capture cannot coincide with out_valid=1, by construction.
- out_data holds its value while out_valid=1 and out_ready=0.

Latency:
- Push at edge E into an empty controller: rd_issue in cycle E+1, capture at edge E+2, out_valid=1 in cycle E+3.
- Sustained pop throughput is one word per 3 cycles.

Boundaries:
- level==DEPTH gives in_ready=0; total capacity is DEPTH+1 words (DEPTH in SRAM plus the output register).
- level==0 with out_valid=0 gives no SRAM read.
- in_valid held with in_ready=0 is a stall; data is not consumed.
- Pointer wrap: after 8 pushes, wr_ptr returns to 0.

Decomposition:
- Shared package sram_pkg holds DATA_W=8, ADDR_W=3, DEPTH=8 and a word typedef, reused by sram1 and its testbench.
- No sub-module. The top-level bench instantiates sram_fifo_ctrl and sram1 side by side.

Test Plan:
- Reset then single push 8'hAA: cycle 1 shows sram_wr=1, sram_add=0; then sram_rd=1, sram_add=0; out_valid=1 with out_data=8'hAA three cycles after the push edge; level returns to 0.
- Fill: push 9 words 8'h10..8'h18 with out_ready=0. First word goes to the output register. level reaches 8 and in_ready=0; a 10th push stalls.
- Drain: from full, hold out_ready=1. Reads come out in order 8'h10..8'h18 at one word per 3 cycles. Addresses wrap 7->0 correctly. Final state is level=0, out_valid=0.
- Contention: in_valid held high while rd_issue is pending. in_ready=0 in that cycle and sram_wr, sram_rd are never both 1. The push completes the next cycle.
- Wrap: 20 interleaved push/pop pairs with data = index. Output sequence is 0..19 with no loss or duplication.
- Reset mid-read: assert rst in the cycle after sram_rd=1. out_valid stays 0, level=0, and the next push of 8'h55 reads back from address 0.
